mse_collector_multi: RTL and testbench

Parametrised error-statistics engine for the word-length-optimisation (WLO) system. It replaces per-candidate data collectors with one block that compares NUM_CAND candidate DSP outputs against a full-precision reference output. For each candidate it accumulates the squared error over a programmable sample window, after discarding a pipeline warm-up period. It reports all per-candidate sums or means together, with one valid pulse, to the control unit.

---
 rtl/mse_collector_multi_pkg.sv | 30 +++
 rtl/mse_collector_multi_if.sv | 26 ++
 rtl/mse_collector_multi_err_sq_acc.sv | 60 ++++++
 rtl/mse_collector_multi.sv | 117 +++++++++++
 tb/tb_mse_collector_multi.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mse_collector_multi_pkg.sv
// Shared definitions for the WLO error-statistics collector: FSM states,
// square-width helper and the saturating accumulate used by every lane.
package wlo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WARMUP,
      ST_ACCUM,
      ST_DRAIN,
      ST_DONE
   } coll_state_e;

   // Widest accumulator the saturating adder supports (ACC_WL <= SAT_W).
   localparam int SAT_W = 128;

   function automatic int sq_width(input int data_wl);
      return 2 * data_wl + 2;
   endfunction

   // Returns {saturated, min(a + b, lim)}; callers zero-extend to SAT_W.
   function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input logic [SAT_W-1:0] lim);
      logic [SAT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, lim}) return {1'b1, lim};
      return {1'b0, sum[SAT_W-1:0]};
   endfunction

endpackage

// File: rtl/mse_collector_multi_if.sv
// Sample/result bundle between the WLO control unit and the collector.
interface mse_collector_multi_if #(
   parameter int NUM_CAND = 2,
   parameter int DATA_WL  = 16,
   parameter int ACC_WL   = 64
);
   logic                      start;
   logic                      mean_en;
   logic                      sample_valid;
   logic signed [DATA_WL-1:0] data_in [NUM_CAND-1:0];
   logic signed [DATA_WL-1:0] data_ref;
   logic                      busy;
   logic [ACC_WL-1:0]         mse_data [NUM_CAND-1:0];
   logic                      mse_valid;
   logic [NUM_CAND-1:0]       ovf;

   modport master (
      output start, mean_en, sample_valid, data_in, data_ref,
      input  busy, mse_data, mse_valid, ovf
   );

   modport slave (
      input  start, mean_en, sample_valid, data_in, data_ref,
      output busy, mse_data, mse_valid, ovf
   );
endinterface

// File: rtl/mse_collector_multi_err_sq_acc.sv
// One candidate lane: diff -> square -> saturating accumulate, each stage
// carrying its own valid bit; ovf sticks until the next clear.
module err_sq_acc
   import wlo_pkg::*;
#(
   parameter int DATA_WL = 16,
   parameter int ACC_WL  = 64
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      clr_i,
   input  logic                      vld_i,
   input  logic signed [DATA_WL-1:0] din_i,
   input  logic signed [DATA_WL-1:0] dref_i,
   output logic [ACC_WL-1:0]         acc_o,
   output logic                      ovf_o
);

   localparam int SQ_W = sq_width(DATA_WL);
   localparam logic [SAT_W-1:0] ACC_MAX = SAT_W'({ACC_WL{1'b1}});

   logic [1:0]               vld_pipe_q;
   logic signed [DATA_WL:0]  diff_d, diff_q;
   logic signed [SQ_W-1:0]   sq_d;
   logic [SQ_W-1:0]          sq_q;
   logic [SAT_W:0]           sum_d;
   logic [ACC_WL-1:0]        acc_q;
   logic                     ovf_q;

   always_comb begin
      diff_d = (DATA_WL+1)'(din_i) - (DATA_WL+1)'(dref_i);
      sq_d   = SQ_W'(diff_q) * SQ_W'(diff_q);
      sum_d  = sat_add(SAT_W'(acc_q), SAT_W'(sq_q), ACC_MAX);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_pipe_q <= '0;
         diff_q     <= '0;
         sq_q       <= '0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         vld_pipe_q <= {vld_pipe_q[0], vld_i};
         diff_q     <= diff_d;
         sq_q       <= SQ_W'(sq_d);
         if (clr_i) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
         end else if (vld_pipe_q[1]) begin
            acc_q <= ACC_WL'(sum_d);
            ovf_q <= ovf_q | sum_d[SAT_W];
         end
      end
   end

   assign acc_o = acc_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/mse_collector_multi.sv
// Multi-candidate squared-error collector: run FSM, sample counters and the
// result registers shared by NUM_CAND err_sq_acc lanes.
module mse_collector_multi
   import wlo_pkg::*;
#(
   parameter int NUM_CAND     = 2,
   parameter int DATA_WL      = 16,
   parameter int ACC_WL       = 64,
   parameter int LOG2_SAMPLES = 16,
   parameter int WARMUP       = 32
) (
   input logic                  clk,
   input logic                  rstn,
   mse_collector_multi_if.slave bus
);

   localparam logic [31:0] WARM_LAST = 32'(WARMUP - 1);
   localparam logic [31:0] ACC_LAST  = 32'((64'd1 << LOG2_SAMPLES) - 64'd1);

   coll_state_e                     state_q, state_d;
   logic [31:0]                     cnt_q, cnt_d;
   logic                            mean_q;
   logic                            busy_c, clr_c, tag_c, load_c;
   logic [NUM_CAND-1:0][ACC_WL-1:0] acc;
   logic [NUM_CAND-1:0]             acc_ovf;
   logic [NUM_CAND-1:0][ACC_WL-1:0] mse_q;
   logic [NUM_CAND-1:0]             ovf_q;
   logic                            valid_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt_q counts accepted samples in WARMUP/ACCUM and flush cycles in DRAIN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: if (bus.start) begin
            cnt_d   = '0;
            state_d = (WARMUP == 0) ? ST_ACCUM : ST_WARMUP;
         end
         ST_WARMUP: if (bus.sample_valid) begin
            if (cnt_q == WARM_LAST) begin
               cnt_d   = '0;
               state_d = ST_ACCUM;
            end else cnt_d = cnt_q + 32'd1;
         end
         ST_ACCUM: if (bus.sample_valid) begin
            if (cnt_q == ACC_LAST) begin
               cnt_d   = '0;
               state_d = ST_DRAIN;
            end else cnt_d = cnt_q + 32'd1;
         end
         ST_DRAIN: begin
            if (cnt_q == 32'd1) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else cnt_d = cnt_q + 32'd1;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_c = (state_q != ST_IDLE);
      clr_c  = (state_q == ST_IDLE) && bus.start;
      tag_c  = (state_q == ST_ACCUM) && bus.sample_valid;
      load_c = (state_q == ST_DONE);
   end

   for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
      err_sq_acc #(
         .DATA_WL (DATA_WL),
         .ACC_WL  (ACC_WL)
      ) u_lane (
         .clk    (clk),
         .rstn   (rstn),
         .clr_i  (clr_c),
         .vld_i  (tag_c),
         .din_i  (bus.data_in[g]),
         .dref_i (bus.data_ref),
         .acc_o  (acc[g]),
         .ovf_o  (acc_ovf[g])
      );
      assign bus.mse_data[g] = mse_q[g];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mean_q  <= 1'b0;
         valid_q <= 1'b0;
         ovf_q   <= '0;
         mse_q   <= '0;
      end else begin
         valid_q <= load_c;
         if (clr_c) mean_q <= bus.mean_en;
         if (load_c) begin
            ovf_q <= acc_ovf;
            for (int i = 0; i < NUM_CAND; i++)
               mse_q[i] <= mean_q ? (acc[i] >> LOG2_SAMPLES) : acc[i];
         end
      end
   end

   assign bus.busy      = busy_c;
   assign bus.mse_valid = valid_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mse_collector_multi.sv
// Randomised scoreboard bench: a 64-bit and an 8-bit accumulator build of the
// collector share one stimulus stream and are checked against a sum-of-squares model.
module tb_mse_collector_multi;

   localparam int NC = 2;
   localparam int DW = 16;
   localparam int L2 = 2;
   localparam int WU = 1;
   localparam int NS = WU + (1 << L2);
   localparam logic [127:0] MAX64 = {64'd0, {64{1'b1}}};
   localparam logic [127:0] MAX8  = 128'd255;

   typedef struct {
      logic [NC-1:0][127:0] d;
      logic [NC-1:0]        ovf;
      int                   cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic start = 1'b0, mean_en = 1'b0, sample_valid = 1'b0;
   logic signed [DW-1:0] din [NC-1:0];
   logic signed [DW-1:0] dref;
   logic signed [DW-1:0] sdi [NS][NC];
   logic signed [DW-1:0] sdr [NS];

   int   checks = 0, failures = 0, cyc = 0;
   exp_t q64[$], q8[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mse_collector_multi_if #(.NUM_CAND(NC), .DATA_WL(DW), .ACC_WL(64)) b64 ();
   mse_collector_multi_if #(.NUM_CAND(NC), .DATA_WL(DW), .ACC_WL(8))  b8 ();

   assign b64.start = start;        assign b8.start = start;
   assign b64.mean_en = mean_en;    assign b8.mean_en = mean_en;
   assign b64.sample_valid = sample_valid;
   assign b8.sample_valid  = sample_valid;
   assign b64.data_in = din;        assign b8.data_in = din;
   assign b64.data_ref = dref;      assign b8.data_ref = dref;

   mse_collector_multi #(.NUM_CAND(NC), .DATA_WL(DW), .ACC_WL(64),
      .LOG2_SAMPLES(L2), .WARMUP(WU)) u64 (.clk(clk), .rstn(rstn), .bus(b64));
   mse_collector_multi #(.NUM_CAND(NC), .DATA_WL(DW), .ACC_WL(8),
      .LOG2_SAMPLES(L2), .WARMUP(WU)) u8 (.clk(clk), .rstn(rstn), .bus(b8));

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_data();
      dref   = DW'($urandom);
      din[0] = DW'($urandom);
      din[1] = DW'($urandom);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy64"}, b64.busy, 0);       chk({tag, "_busy8"}, b8.busy, 0);
      chk({tag, "_vld64"}, b64.mse_valid, 0);   chk({tag, "_vld8"}, b8.mse_valid, 0);
      chk({tag, "_d64_0"}, b64.mse_data[0], 0); chk({tag, "_d64_1"}, b64.mse_data[1], 0);
      chk({tag, "_d8_0"}, b8.mse_data[0], 0);   chk({tag, "_d8_1"}, b8.mse_data[1], 0);
      chk({tag, "_ovf64"}, b64.ovf, 0);         chk({tag, "_ovf8"}, b8.ovf, 0);
   endtask

   // Monitors: every mse_valid pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (b64.mse_valid) begin
         chk("v64_expected", 128'(q64.size() != 0), 1);
         if (q64.size() != 0) begin
            e = q64.pop_front();
            chk("d64_c0", b64.mse_data[0], e.d[0]);
            chk("d64_c1", b64.mse_data[1], e.d[1]);
            chk("ovf64", b64.ovf, e.ovf);
            chk("cyc64", cyc, e.cyc);
            chk("busy64_at_valid", b64.busy, 0);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (b8.mse_valid) begin
         chk("v8_expected", 128'(q8.size() != 0), 1);
         if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("d8_c0", b8.mse_data[0], e.d[0]);
            chk("d8_c1", b8.mse_data[1], e.d[1]);
            chk("ovf8", b8.ovf, e.ovf);
            chk("cyc8", cyc, e.cyc);
         end
      end
   end

   // pat: 0 equal, 1 err +3/-5 (warm-up err +10/-10), 2 extremes, 3 err 16, else random.
   // gap: 0 continuous, 1 alternate valid/idle, else random.
   task automatic run(input bit mean, input int pat, input int gap, input bit rep);
      exp_t e64, e8;
      int   last, n;
      bit   v;
      for (int k = 0; k < NS; k++) begin
         case (pat)
            0: begin sdr[k] = 16'sd1000; sdi[k][0] = 16'sd1000; sdi[k][1] = 16'sd1000; end
            1: begin
               sdr[k] = 16'sd1000;
               sdi[k][0] = (k < WU) ? 16'sd1010 : 16'sd1003;
               sdi[k][1] = (k < WU) ? 16'sd990  : 16'sd995;
            end
            2: begin sdr[k] = 16'sh7FFF; sdi[k][0] = 16'sh8000; sdi[k][1] = 16'sh7FFF; end
            3: begin sdr[k] = 16'sd0; sdi[k][0] = 16'sd16; sdi[k][1] = 16'sd0; end
            default: begin
               sdr[k] = DW'($urandom); sdi[k][0] = DW'($urandom); sdi[k][1] = DW'($urandom);
            end
         endcase
      end
      for (int c = 0; c < NC; c++) begin
         logic [127:0] tot;
         longint       d;
         tot = '0;
         for (int k = WU; k < NS; k++) begin
            d = longint'(sdi[k][c]) - longint'(sdr[k]);
            tot += 128'(d * d);
         end
         e64.d[c]   = ((tot > MAX64) ? MAX64 : tot) >> (mean ? L2 : 0);
         e64.ovf[c] = (tot > MAX64);
         e8.d[c]    = ((tot > MAX8) ? MAX8 : tot) >> (mean ? L2 : 0);
         e8.ovf[c]  = (tot > MAX8);
      end

      chk("busy_before_start", b64.busy, 0);
      start = 1'b1; mean_en = mean; sample_valid = 1'($urandom); rand_data();
      n = 0; last = cyc;
      while (n < NS) begin
         tick();
         start   = rep && (n == WU + 2);
         mean_en = ~mean;
         chk("busy64_run", b64.busy, 1);
         chk("busy8_run", b8.busy, 1);
         if (gap == 0)      v = 1'b1;
         else if (gap == 1) v = ((cyc - last) % 2 == 1) || (n == 0 && (cyc - last) == 1);
         else               v = 1'($urandom);
         if (v) begin
            dref = sdr[n]; din[0] = sdi[n][0]; din[1] = sdi[n][1];
            sample_valid = 1'b1; last = cyc; n++;
         end else begin
            rand_data(); sample_valid = 1'b0;
         end
      end
      e64.cyc = last + 4; e8.cyc = last + 4;
      q64.push_back(e64); q8.push_back(e8);
      repeat (3) begin
         tick();
         start = 1'b0; sample_valid = 1'($urandom); rand_data();
         chk("busy_drain", b64.busy, 1);
      end
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic reset_mid();
      start = 1'b1; mean_en = 1'b0; sample_valid = 1'b1; rand_data();
      repeat (4) begin
         tick();
         start = 1'b0; sample_valid = 1'b1; rand_data();
      end
      #2 rstn = 1'b0;
      @(negedge clk);
      chk_zero("midrst");
      #1 rstn = 1'b1;
      sample_valid = 1'b0;
      tick();
   endtask

   initial begin
      dref = '0; din[0] = '0; din[1] = '0;
      repeat (3) tick();
      chk_zero("rst");
      rstn = 1'b1;
      tick();
      run(0, 0, 0, 0);
      run(0, 1, 0, 0); run(1, 1, 0, 0);
      run(0, 1, 1, 0); run(1, 1, 1, 0);
      run(0, 2, 0, 0); run(1, 2, 0, 0);
      run(0, 3, 0, 0); run(1, 3, 0, 0);
      run(1, 4, 2, 1);
      reset_mid();
      run(0, 1, 0, 0);
      for (int i = 0; i < 6; i++) run(1'(i % 2), 4, 2, (i % 3) == 0);
      tick();
      chk("q64_drained", q64.size(), 0);
      chk("q8_drained", q8.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
